// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_pkg
//  Description : Shared widths, FSM encodings and response-latency bounds
//                for the simple bus scratchpad target.
//  Revision    : 1.0  initial release
// ============================================================================
package bus_pkg;

  // Default bus widths; the write mask carries one bit per data byte
  localparam int BUS_ADDR_WIDTH  = 32;
  localparam int BUS_DATA_WIDTH  = 32;
  localparam int BUS_WMASK_WIDTH = BUS_DATA_WIDTH / 8;

  // Legal range of the request-to-response latency
  localparam int RESP_LATENCY_MIN = 1;
  localparam int RESP_LATENCY_MAX = 4;

  // Target FSM: S_CLEAR sweeps zeros through storage, S_READY serves requests
  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } sp_state_e;

endpackage
`default_nettype wire

// File: rtl/bus_scratchpad_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_scratchpad_if
//  Description : Simple request/response bus between the AXI-Lite bridge
//                (master) and a memory target (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface bus_scratchpad_if
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH = BUS_ADDR_WIDTH,
  parameter int DATA_WIDTH = BUS_DATA_WIDTH
);

  logic                    bus_req_valid;
  logic                    bus_req_ready;
  logic [ADDR_WIDTH-1:0]   bus_req_addr;
  logic                    bus_req_wen;
  logic [DATA_WIDTH/8-1:0] bus_req_wmask;
  logic [DATA_WIDTH-1:0]   bus_req_data;
  logic                    bus_resp_valid;
  logic [DATA_WIDTH-1:0]   bus_resp_data;

  modport master (
    output bus_req_valid, bus_req_addr, bus_req_wen, bus_req_wmask, bus_req_data,
    input  bus_req_ready, bus_resp_valid, bus_resp_data
  );

  modport slave (
    input  bus_req_valid, bus_req_addr, bus_req_wen, bus_req_wmask, bus_req_data,
    output bus_req_ready, bus_resp_valid, bus_resp_data
  );

endinterface
`default_nettype wire

// File: rtl/bus_scratchpad_ram.sv
`default_nettype none
// ============================================================================
//  Module      : bus_scratchpad_ram
//  Description : Single-port DEPTH_WORDS x DATA_WIDTH storage with byte write
//                enables and a one-cycle registered read. Contents are never
//                reset.
//  Revision    : 1.0  initial release
// ============================================================================
module bus_scratchpad_ram #(
  parameter  int DEPTH_WORDS = 1024,
  parameter  int DATA_WIDTH  = 32,
  localparam int IDX_W       = $clog2(DEPTH_WORDS),
  localparam int NB          = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [NB-1:0]         be_i,
  input  logic [IDX_W-1:0]      addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Byte-lane writes and registered read share the single address port
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/bus_scratchpad.sv
`default_nettype none
// ============================================================================
//  Module      : bus_scratchpad
//  Description : Word-addressed scratchpad target on the simple bus. Byte-
//                masked writes, synchronous reads, one in-order response per
//                accepted request after a fixed RESP_LATENCY.
//                Optional macro SCRATCHPAD_CLEAR_EN: zero-fill storage after
//                reset before accepting requests.
//  Revision    : 1.0  initial release
// ============================================================================
module bus_scratchpad
  import bus_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = BUS_ADDR_WIDTH,
  parameter int                    DATA_WIDTH   = BUS_DATA_WIDTH,
  parameter int                    DEPTH_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                    RESP_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  bus_scratchpad_if.slave   bus_io
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int NB    = DATA_WIDTH / 8;
  // Byte span of the storage, one bit wider so the compare cannot overflow
  localparam logic [ADDR_WIDTH:0] c_span_bytes = (ADDR_WIDTH+1)'(DEPTH_WORDS * 4);

`ifdef SCRATCHPAD_CLEAR_EN
  localparam sp_state_e c_reset_state = S_CLEAR;
`else
  localparam sp_state_e c_reset_state = S_READY;
`endif

  sp_state_e state_q;
`ifdef SCRATCHPAD_CLEAR_EN
  logic [IDX_W-1:0] clr_cnt_q;
`endif

  logic                  w_ready;
  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_off;
  logic                  w_in_range;
  logic [IDX_W-1:0]      w_idx;

  logic                  ram_we;
  logic [NB-1:0]         ram_be;
  logic [IDX_W-1:0]      ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_re;
  logic [DATA_WIDTH-1:0] ram_rdata;

  logic                  s1_vld_q;
  logic                  s1_rd_q;
  logic [DATA_WIDTH-1:0] w_s1_data;

  // Ready drops immediately with reset so nothing is accepted while it is held
  assign w_ready  = (state_q == S_READY) && !reset;
  assign w_accept = bus_io.bus_req_valid && w_ready;
  assign bus_io.bus_req_ready = w_ready;

  // Offset from the window base; wrap-around below the base lands out of range
  assign w_off      = bus_io.bus_req_addr - BASE_ADDR;
  assign w_in_range = ({1'b0, w_off} < c_span_bytes);
  assign w_idx      = w_off[IDX_W+1:2];

  // Storage port: clear sweep owns it in S_CLEAR, otherwise the accepted request
  always_comb begin
    ram_we    = w_accept && bus_io.bus_req_wen && w_in_range;
    ram_be    = bus_io.bus_req_wmask;
    ram_addr  = w_idx;
    ram_wdata = bus_io.bus_req_data;
    ram_re    = w_accept && !bus_io.bus_req_wen && w_in_range;
`ifdef SCRATCHPAD_CLEAR_EN
    if (state_q == S_CLEAR) begin
      ram_we    = 1'b1;
      ram_be    = '1;
      ram_addr  = clr_cnt_q;
      ram_wdata = '0;
      ram_re    = 1'b0;
    end
`endif
  end

  bus_scratchpad_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .rdata_o (ram_rdata)
  );

  // Target FSM with clear-sweep counter; reset restarts any sweep from word 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= c_reset_state;
`ifdef SCRATCHPAD_CLEAR_EN
      clr_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        S_CLEAR: begin
`ifdef SCRATCHPAD_CLEAR_EN
          clr_cnt_q <= clr_cnt_q + IDX_W'(1);
          if (clr_cnt_q == IDX_W'(DEPTH_WORDS - 1)) begin
            state_q <= S_READY;
          end
`else
          state_q <= S_READY;
`endif
        end
        default: state_q <= S_READY;
      endcase
    end
  end

  // Stage 1 tracks the cycle in which the RAM read register is loaded
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld_q <= 1'b0;
      s1_rd_q  <= 1'b0;
    end else begin
      s1_vld_q <= w_accept;
      s1_rd_q  <= w_accept && !bus_io.bus_req_wen && w_in_range;
    end
  end

  // Only in-range reads return storage; writes, misses and idle cycles give 0
  assign w_s1_data = s1_rd_q ? ram_rdata : '0;

  generate
    if (RESP_LATENCY == 1) begin : g_lat_one
      assign bus_io.bus_resp_valid = s1_vld_q;
      assign bus_io.bus_resp_data  = w_s1_data;
    end else begin : g_lat_multi
      logic [RESP_LATENCY:2]  vld_q;
      logic [DATA_WIDTH-1:0]  dat_q [RESP_LATENCY:2];

      // Remaining stages shift valid and already-masked data toward the output
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          vld_q <= '0;
          for (int k = 2; k <= RESP_LATENCY; k++) begin
            dat_q[k] <= '0;
          end
        end else begin
          vld_q[2] <= s1_vld_q;
          dat_q[2] <= w_s1_data;
          for (int k = 3; k <= RESP_LATENCY; k++) begin
            vld_q[k] <= vld_q[k-1];
            dat_q[k] <= dat_q[k-1];
          end
        end
      end

      assign bus_io.bus_resp_valid = vld_q[RESP_LATENCY];
      assign bus_io.bus_resp_data  = dat_q[RESP_LATENCY];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_bus_scratchpad.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_scratchpad
//  Description : Self-checking bench for bus_scratchpad: vector table plus
//                hand sequences, responses matched through a scoreboard queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bus_scratchpad;

  localparam int          LAT   = 3;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0100;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    bit          chk;
    int          due;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_err;
  exp_t sb[$];

  bus_scratchpad_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  bus_scratchpad #(
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (32),
    .DEPTH_WORDS  (DEPTH),
    .BASE_ADDR    (BASE),
    .RESP_LATENCY (LAT)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one request for a cycle; expected response queued only if it will be accepted
  task automatic send(input logic [31:0] a, input logic w, input logic [3:0] m,
                      input logic [31:0] d, input logic [31:0] e,
                      input bit chkd, input bit expect_resp);
    bus.bus_req_valid = 1'b1;
    bus.bus_req_addr  = a;
    bus.bus_req_wen   = w;
    bus.bus_req_wmask = m;
    bus.bus_req_data  = d;
    if (expect_resp && bus.bus_req_ready === 1'b1) begin
      sb.push_back('{data: e, chk: chkd, due: cyc + LAT});
    end
    @(negedge clk);
  endtask

  task automatic idle();
    bus.bus_req_valid = 1'b0;
    bus.bus_req_wen   = 1'b0;
    bus.bus_req_wmask = 4'h0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_outstanding", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (bus.bus_req_ready !== 1'b1 && n < 500) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Response monitor: sample just before each rising edge, pop and compare
  always begin
    @(negedge clk);
    #4;
    if (bus.bus_resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_resp: got resp_valid=1 data=%h, expected no response (cycle %0d)",
                 bus.bus_resp_data, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_cycle", 32'(cyc), 32'(e.due));
        if (e.chk) check("resp_data", bus.bus_resp_data, e.data);
      end
    end else begin
      check("idle_resp_data_zero", bus.bus_resp_data, 32'h0);
    end
  end

  vec_t        vt [0:18];
  logic [31:0] mdl [0:15];
  logic [31:0] after_rst_exp;

  initial begin
    int n;
    n_checks = 0;
    n_err    = 0;
    cyc      = 0;
    reset    = 1'b1;
    bus.bus_req_valid = 1'b0;
    bus.bus_req_addr  = '0;
    bus.bus_req_wen   = 1'b0;
    bus.bus_req_wmask = '0;
    bus.bus_req_data  = '0;

    vt[0]  = '{BASE + 32'h20,  1'b1, 4'hF, 32'h1234_5678, 32'h0};
    vt[1]  = '{BASE + 32'h20,  1'b1, 4'h5, 32'hAABB_CCDD, 32'h0};
    vt[2]  = '{BASE + 32'h20,  1'b0, 4'h0, 32'h0,         32'h12BB_56DD};
    vt[3]  = '{BASE + 32'h40,  1'b1, 4'hF, 32'hCAFE_F00D, 32'h0};
    vt[4]  = '{BASE + 32'h40,  1'b0, 4'h0, 32'h0,         32'hCAFE_F00D};
    vt[5]  = '{BASE + 32'h00,  1'b1, 4'hF, 32'h1122_3344, 32'h0};
    vt[6]  = '{BASE + 32'h100, 1'b0, 4'h0, 32'h0,         32'h0};
    vt[7]  = '{BASE + 32'h100, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0};
    vt[8]  = '{BASE + 32'h00,  1'b0, 4'h0, 32'h0,         32'h1122_3344};
    vt[9]  = '{BASE + 32'h44,  1'b1, 4'hF, 32'h0,         32'h0};
    vt[10] = '{BASE + 32'h44,  1'b1, 4'hA, 32'hDEAD_BEEF, 32'h0};
    vt[11] = '{BASE + 32'h44,  1'b0, 4'h0, 32'h0,         32'hDE00_BE00};
    vt[12] = '{BASE + 32'h40,  1'b1, 4'h0, 32'hFFFF_FFFF, 32'h0};
    vt[13] = '{BASE + 32'h40,  1'b0, 4'h0, 32'h0,         32'hCAFE_F00D};
    vt[14] = '{BASE + 32'hFC,  1'b1, 4'hF, 32'h0BAD_CAFE, 32'h0};
    vt[15] = '{BASE + 32'hFC,  1'b0, 4'h0, 32'h0,         32'h0BAD_CAFE};
    vt[16] = '{BASE - 32'h4,   1'b0, 4'h0, 32'h0,         32'h0};
    vt[17] = '{BASE + 32'h23,  1'b0, 4'h0, 32'h0,         32'h12BB_56DD};
    vt[18] = '{32'hFFFF_FFFC,  1'b0, 4'h0, 32'h0,         32'h0};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_ready", 32'(bus.bus_req_ready), 32'd0);
    check("reset_resp_valid", 32'(bus.bus_resp_valid), 32'd0);
    check("reset_resp_data", bus.bus_resp_data, 32'h0);
    reset = 1'b0;

`ifdef SCRATCHPAD_CLEAR_EN
    // Interrupt the sweep part way, then expect a full-length sweep again
    n = 0;
    while (bus.bus_req_ready !== 1'b1 && n < 8) begin
      n++;
      @(negedge clk);
    end
    check("clear_ready_low_mid", 32'(bus.bus_req_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_ready(n);
    check("clear_sweep_cycles", 32'(n), 32'(DEPTH));
    send(BASE + 32'h10, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    send(BASE + 32'h14, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1);
`else
    @(negedge clk);
    check("ready_after_reset", 32'(bus.bus_req_ready), 32'd1);
    // Contents are undefined before any write: check response timing only
    send(BASE + 32'h10, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
`endif
    idle();
    drain();

    // Vector table, applied back-to-back
    for (int i = 0; i <= 18; i++) begin
      send(vt[i].addr, vt[i].wen, vt[i].mask, vt[i].data, vt[i].exp, 1'b1, 1'b1);
    end
    idle();
    drain();

    // Randomised traffic on words 32..47 against a reference array
    for (int k = 0; k < 16; k++) begin
      mdl[k] = $urandom;
      send(BASE + 32'h80 + 32'(k*4), 1'b1, 4'hF, mdl[k], 32'h0, 1'b1, 1'b1);
    end
    for (int t = 0; t < 60; t++) begin
      int          k;
      logic        w;
      logic [3:0]  m;
      logic [31:0] d;
      k = $urandom_range(0, 15);
      w = 1'($urandom_range(0, 1));
      m = 4'($urandom);
      d = $urandom;
      if (w) begin
        send(BASE + 32'h80 + 32'(k*4), 1'b1, m, d, 32'h0, 1'b1, 1'b1);
        for (int b = 0; b < 4; b++) begin
          if (m[b]) mdl[k][b*8 +: 8] = d[b*8 +: 8];
        end
      end else begin
        send(BASE + 32'h80 + 32'(k*4), 1'b0, 4'h0, 32'h0, mdl[k], 1'b1, 1'b1);
      end
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(negedge clk);
      end
    end
    idle();
    drain();

    // In-flight read dropped by reset; requests during reset are ignored
    send(BASE + 32'h20, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    reset = 1'b1;
    bus.bus_req_valid = 1'b1;
    bus.bus_req_addr  = BASE + 32'h20;
    bus.bus_req_wen   = 1'b1;
    bus.bus_req_wmask = 4'hF;
    bus.bus_req_data  = 32'h0;
    #1;
    check("midrun_reset_ready", 32'(bus.bus_req_ready), 32'd0);
    check("midrun_reset_resp_valid", 32'(bus.bus_resp_valid), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle();
`ifdef SCRATCHPAD_CLEAR_EN
    wait_ready(n);
    after_rst_exp = 32'h0;
`else
    @(negedge clk);
    after_rst_exp = 32'h12BB_56DD;
`endif
    check("ready_after_midrun_reset", 32'(bus.bus_req_ready), 32'd1);
    send(BASE + 32'h20, 1'b0, 4'h0, 32'h0, after_rst_exp, 1'b1, 1'b1);
    idle();
    repeat (LAT + 4) @(negedge clk);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
